// File: rtl/pixmem_pkg.sv
// rtl/pixmem_pkg.sv - shared defaults, colour constants and state encoding for pixel_mem_writer
package pixmem_pkg;

    localparam int BLOCKS_DEF = 24;
    localparam int BPB_DEF    = 2;

    localparam logic [1:0] BLACK  = 2'b00;
    localparam logic [1:0] RED    = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] YELLOW = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/pixel_mem_writer_if.sv
// rtl/pixel_mem_writer_if.sv - block-write / clear request bundle for pixel_mem_writer
interface pixel_mem_writer_if
    import pixmem_pkg::*;
#(
    parameter int BPB = BPB_DEF
);
    logic           wr_valid;
    logic           wr_ready;
    logic [4:0]     wr_index;
    logic [BPB-1:0] wr_color;
    logic           clr_req;

    modport master (
        output wr_valid,
        output wr_index,
        output wr_color,
        output clr_req,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_index,
        input  wr_color,
        input  clr_req,
        output wr_ready
    );
endinterface

// File: rtl/vsync_edge_detect.sv
// rtl/vsync_edge_detect.sv - 2-flop vsync synchroniser with a one-cycle falling-edge tick
module vsync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic tick
);
    logic sync_1;
    logic sync_2;
    logic sync_2_d;

    // Flops idle high so that releasing reset with vsync high yields no tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1   <= 1'b1;
            sync_2   <= 1'b1;
            sync_2_d <= 1'b1;
        end else begin
            sync_1   <= vsync;
            sync_2   <= sync_1;
            sync_2_d <= sync_2;
        end
    end

    assign tick = sync_2_d & ~sync_2;
endmodule

// File: rtl/pixel_mem_writer.sv
// rtl/pixel_mem_writer.sv - block frame image writer with clear sequencer; PIXMEM_DOUBLE_BUFFER_EN adds a vsync-committed front buffer
module pixel_mem_writer
    import pixmem_pkg::*;
#(
    parameter int BLOCKS = BLOCKS_DEF,
    parameter int BPB    = BPB_DEF
) (
    input  logic                  clk,
    input  logic                  rst_btn,
    pixel_mem_writer_if.slave     wr,
    input  logic                  vsync,
    output logic [BLOCKS*BPB-1:0] pixelMemory,
    output logic                  busy,
    output logic                  err_index
);
    localparam int CNT_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

    state_t                  state;
    logic [CNT_W-1:0]        clr_cnt;
    logic [BLOCKS*BPB-1:0]   image;
    logic                    err_q;
    logic                    accept;
    logic                    in_range;

    // A same-cycle clear request wins over a write, so the write is refused here.
    assign wr.wr_ready = (state == IDLE) && !wr.clr_req && !rst_btn;
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign in_range    = int'(wr.wr_index) < BLOCKS;
    assign busy        = (state == CLEAR);
    assign err_index   = err_q;

    always_ff @(posedge clk or posedge rst_btn) begin
        if (rst_btn) begin
            state   <= IDLE;
            clr_cnt <= '0;
            image   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && !in_range;
            case (state)
                IDLE: begin
                    if (wr.clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end else if (accept && in_range) begin
                        for (int i = 0; i < BLOCKS; i++) begin
                            if (i == int'(wr.wr_index)) begin
                                image[i*BPB +: BPB] <= wr.wr_color;
                            end
                        end
                    end
                end
                CLEAR: begin
                    for (int i = 0; i < BLOCKS; i++) begin
                        if (i == int'(clr_cnt)) begin
                            image[i*BPB +: BPB] <= '0;
                        end
                    end
                    if (clr_cnt == CNT_W'(BLOCKS - 1)) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef PIXMEM_DOUBLE_BUFFER_EN
    logic                  frame_tick;
    logic                  dirty;
    logic                  image_change;
    logic [BLOCKS*BPB-1:0] front;

    vsync_edge_detect u_vsync_edge_detect (
        .clk   (clk),
        .rst   (rst_btn),
        .vsync (vsync),
        .tick  (frame_tick)
    );

    assign image_change = (accept && in_range) || (state == CLEAR);

    // The commit samples image before this edge's update, so a coincident
    // change stays dirty and lands on the following frame.
    always_ff @(posedge clk or posedge rst_btn) begin
        if (rst_btn) begin
            front <= '0;
            dirty <= 1'b0;
        end else begin
            if (frame_tick && dirty) begin
                front <= image;
            end
            if (image_change) begin
                dirty <= 1'b1;
            end else if (frame_tick) begin
                dirty <= 1'b0;
            end
        end
    end

    assign pixelMemory = front;
`else
    wire vsync_unused = vsync;

    assign pixelMemory = image;
`endif
endmodule
